// File: rtl/vend_if.sv
// Handshake bundle between the vending FSM side and the dispenser.
// Inputs come from the controller and sensors; outputs drive the mechanics.
interface vend_if;
    logic       sell;
    logic [1:0] change;
    logic       drink_sensor;
    logic       coin_sensor;
    logic       clr_fault;
    logic       motor_on;
    logic       eject_on;
    logic       busy;
    logic       done;
    logic [2:0] fault;

    modport master (
        output sell, change, drink_sensor, coin_sensor, clr_fault,
        input  motor_on, eject_on, busy, done, fault
    );

    modport slave (
        input  sell, change, drink_sensor, coin_sensor, clr_fault,
        output motor_on, eject_on, busy, done, fault
    );
endinterface

// File: rtl/vend_dispenser.sv
// Drink motor / coin ejector sequencer with sensor timeouts,
// a one-deep order buffer and sticky fault flags.
module vend_dispenser #(
    parameter int MOTOR_CYCLES = 8,
    parameter int EJECT_CYCLES = 4,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 8
) (
    input logic clk,
    input logic rst,
    vend_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, MOTOR, WAIT_DROP, EJECT, WAIT_COIN, DONE, HALT
    } state_t;

    localparam logic [CNT_W-1:0] MOT_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] EJ_LAST  = CNT_W'(EJECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]       coin_left, coin_n;
    logic             pend_v, pv_n;
    logic [1:0]       pend_chg, pc_n;
    logic [2:0]       fault_q, fault_n, fset;
    logic             coin_q, coin_rise;
    logic             motor_q, eject_q, busy_q, done_q;

    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    assign coin_rise = bus.coin_sensor & ~coin_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        coin_n  = coin_left;
        pv_n    = pend_v;
        pc_n    = pend_chg;
        fset    = '0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.sell) begin
                    state_n = MOTOR;
                    coin_n  = bus.change;
                end
            end
            MOTOR: begin
                if (cnt == MOT_LAST) begin
                    state_n = WAIT_DROP;
                    cnt_n   = '0;
                end
            end
            WAIT_DROP: begin
                if (bus.drink_sensor) begin
                    cnt_n   = '0;
                    state_n = (coin_left != 2'd0) ? EJECT : DONE;
                end else if (cnt == TMO_LAST) begin
                    fset[0] = 1'b1;
                    state_n = HALT;
                end
            end
            EJECT: begin
                if (cnt == EJ_LAST) begin
                    state_n = WAIT_COIN;
                    cnt_n   = '0;
                end
            end
            WAIT_COIN: begin
                // Only a rising sensor edge counts, so a held pulse pays out once.
                if (coin_rise) begin
                    cnt_n   = '0;
                    coin_n  = coin_left - 2'(coin_left != 2'd0);
                    state_n = (coin_left > 2'd1) ? EJECT : DONE;
                end else if (cnt == TMO_LAST) begin
                    fset[1] = 1'b1;
                    state_n = HALT;
                end
            end
            DONE: begin
                cnt_n = '0;
                if (pend_v) begin
                    state_n = MOTOR;
                    coin_n  = pend_chg;
                    pv_n    = 1'b0;
                end else if (bus.sell) begin
                    state_n = MOTOR;
                    coin_n  = bus.change;
                end else begin
                    state_n = IDLE;
                end
            end
            HALT: begin
                cnt_n = '0;
                pv_n  = 1'b0;
                if (bus.clr_fault) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (bus.sell && state inside {MOTOR, WAIT_DROP, EJECT, WAIT_COIN}) begin
            if (pend_v) begin
                fset[2] = 1'b1;
            end else begin
                pv_n = 1'b1;
                pc_n = bus.change;
            end
        end
        if (bus.sell && state == DONE && pend_v) fset[2] = 1'b1;

        fault_n = (bus.clr_fault ? 3'b000 : fault_q) | fset;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            coin_left <= '0;
            pend_v    <= 1'b0;
            pend_chg  <= '0;
            fault_q   <= '0;
            coin_q    <= 1'b0;
            motor_q   <= 1'b0;
            eject_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            coin_left <= coin_n;
            pend_v    <= pv_n;
            pend_chg  <= pc_n;
            fault_q   <= fault_n;
            coin_q    <= bus.coin_sensor;
            motor_q   <= (state_n == MOTOR);
            eject_q   <= (state_n == EJECT);
            busy_q    <= (state_n != IDLE);
            done_q    <= (state_n == DONE);
        end
    end

    assign bus.motor_on = motor_q;
    assign bus.eject_on = eject_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench: expected motor/eject/done events are queued at stimulus
// time and popped by a negedge monitor as the outputs appear.
module tb_vend_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   mrun = 0;
    int   erun = 0;

    localparam int EV_M = 256;
    localparam int EV_E = 512;
    localparam int EV_D = 768;

    vend_if bus();

    vend_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic emit(input string tag, input int code);
        int e;
        if (exp_q.size() == 0) e = -1;
        else e = exp_q.pop_front();
        chk(tag, code, e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mrun = 0;
            erun = 0;
        end else begin
            if (bus.motor_on) mrun++;
            else if (mrun > 0) begin
                emit("motor_pulse", EV_M + mrun);
                mrun = 0;
            end
            if (bus.eject_on) erun++;
            else if (erun > 0) begin
                emit("eject_pulse", EV_E + erun);
                erun = 0;
            end
            if (bus.done) emit("done_pulse", EV_D);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sell(input logic [1:0] chg);
        bus.sell = 1'b1;
        bus.change = chg;
        tick();
        bus.sell = 1'b0;
        bus.change = 2'b00;
    endtask

    task automatic pulse_drink();
        bus.drink_sensor = 1'b1;
        tick();
        bus.drink_sensor = 1'b0;
    endtask

    task automatic pulse_coin();
        bus.coin_sensor = 1'b1;
        tick();
        bus.coin_sensor = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_motor"}, bus.motor_on, 0);
        chk({tag, "_eject"}, bus.eject_on, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_fault"}, bus.fault, 0);
    endtask

    initial begin
        bus.sell = 1'b0;
        bus.change = 2'b00;
        bus.drink_sensor = 1'b0;
        bus.coin_sensor = 1'b0;
        bus.clr_fault = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: plain vend, no change
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_D);
        pulse_sell(2'b00);
        chk("t1_latency", bus.motor_on, 1);
        chk("t1_busy", bus.busy, 1);
        repeat (7) tick();
        chk("t1_motor_last", bus.motor_on, 1);
        tick();
        chk("t1_motor_off", bus.motor_on, 0);
        repeat (2) tick();
        pulse_drink();
        chk("t1_done", bus.done, 1);
        tick();
        chk("t1_done_once", bus.done, 0);
        chk("t1_idle", bus.busy, 0);
        chk("t1_fault", bus.fault, 0);

        // 2: two coins of change
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_E + 4);
        exp_q.push_back(EV_E + 4);
        exp_q.push_back(EV_D);
        pulse_sell(2'b10);
        repeat (8) tick();
        pulse_drink();
        chk("t2_eject1", bus.eject_on, 1);
        repeat (3) tick();
        chk("t2_eject1_last", bus.eject_on, 1);
        tick();
        chk("t2_eject1_off", bus.eject_on, 0);
        repeat (2) tick();
        pulse_coin();
        chk("t2_eject2", bus.eject_on, 1);
        repeat (4) tick();
        repeat (2) tick();
        pulse_coin();
        chk("t2_done", bus.done, 1);
        tick();
        chk("t2_idle", bus.busy, 0);

        // 3: A running, B buffered, C overruns
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_E + 4);
        exp_q.push_back(EV_D);
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_D);
        pulse_sell(2'b01);
        tick();
        pulse_sell(2'b00);
        repeat (6) tick();
        chk("t3_wait_drop", bus.motor_on, 0);
        pulse_sell(2'b11);
        chk("t3_overrun", bus.fault, 3'b100);
        pulse_drink();
        repeat (4) tick();
        pulse_coin();
        chk("t3_done_a", bus.done, 1);
        tick();
        chk("t3_motor_b", bus.motor_on, 1);
        repeat (8) tick();
        pulse_drink();
        chk("t3_done_b", bus.done, 1);
        tick();
        chk("t3_idle", bus.busy, 0);
        chk("t3_fault", bus.fault, 3'b100);
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
        chk("t3_clr", bus.fault, 0);

        // 4: drink timeout
        exp_q.push_back(EV_M + 8);
        pulse_sell(2'b00);
        repeat (8) tick();
        repeat (254) tick();
        chk("t4_pre_tmo", bus.fault, 0);
        tick();
        chk("t4_tmo", bus.fault, 3'b001);
        chk("t4_halt_busy", bus.busy, 1);
        pulse_sell(2'b00);
        tick();
        chk("t4_sell_ignored", bus.motor_on, 0);
        chk("t4_no_overrun", bus.fault, 3'b001);
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
        chk("t4_clr", bus.fault, 0);
        chk("t4_idle", bus.busy, 0);
        tick();
        chk("t4_no_pending", bus.busy, 0);

        // 5: sell coincident with done
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_D);
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_D);
        pulse_sell(2'b00);
        repeat (8) tick();
        pulse_drink();
        chk("t5_done", bus.done, 1);
        pulse_sell(2'b00);
        chk("t5_motor_next", bus.motor_on, 1);
        repeat (8) tick();
        pulse_drink();
        chk("t5_done2", bus.done, 1);
        tick();
        chk("t5_idle", bus.busy, 0);

        // 6: reset mid-eject
        exp_q.push_back(EV_M + 8);
        pulse_sell(2'b11);
        tick();
        pulse_sell(2'b00);
        repeat (6) tick();
        pulse_drink();
        pulse_sell(2'b01);
        chk("t6_overrun", bus.fault, 3'b100);
        tick();
        chk("t6_ejecting", bus.eject_on, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(EV_M + 8);
        exp_q.push_back(EV_D);
        pulse_sell(2'b00);
        chk("t6_latency", bus.motor_on, 1);
        repeat (8) tick();
        pulse_drink();
        chk("t6_done", bus.done, 1);
        tick();
        tick();
        chk("t6_no_pending", bus.busy, 0);
        chk("t6_no_eject", bus.eject_on, 0);

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
